cga_ports: RTL and testbench



---
 rtl/cga_pkg.sv | 43 ++++
 rtl/cga_ports_if.sv | 21 ++
 rtl/cga_dac_port.sv | 130 +++++++++++++
 rtl/cga_ports.sv | 142 ++++++++++++++
 tb/tb_cga_ports.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cga_pkg.sv
// Shared constants, phase enum and helpers for the CGA/VGA I/O register block.
package cga_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned CURSOR_W    = 11;
    localparam int unsigned SHAPE_LO_W  = 6;
    localparam int unsigned SHAPE_HI_W  = 5;
    localparam int unsigned MODE_W      = 2;
    localparam int unsigned CRTC_IDX_W  = 5;
    localparam int unsigned DAC_IDX_W   = 8;
    localparam int unsigned DAC_DATA_W  = 32;
    localparam int unsigned COMP_W      = 6;

    localparam logic [ADDR_W-1:0] PORT_CRTC_INDEX = 16'h03D4;
    localparam logic [ADDR_W-1:0] PORT_CRTC_DATA  = 16'h03D5;
    localparam logic [ADDR_W-1:0] PORT_MODE       = 16'h03D8;
    localparam logic [ADDR_W-1:0] PORT_STATUS     = 16'h03DA;
    localparam logic [ADDR_W-1:0] PORT_DAC_RINDEX = 16'h03C7;
    localparam logic [ADDR_W-1:0] PORT_DAC_WINDEX = 16'h03C8;
    localparam logic [ADDR_W-1:0] PORT_DAC_DATA   = 16'h03C9;

    localparam logic [CRTC_IDX_W-1:0] CRTC_CURSOR_START = 5'h0A;
    localparam logic [CRTC_IDX_W-1:0] CRTC_CURSOR_END   = 5'h0B;
    localparam logic [CRTC_IDX_W-1:0] CRTC_CURSOR_HI    = 5'h0E;
    localparam logic [CRTC_IDX_W-1:0] CRTC_CURSOR_LO    = 5'h0F;

    localparam logic [SHAPE_LO_W-1:0] CURSOR_SHAPE_LO_RST = 6'd14;
    localparam logic [SHAPE_HI_W-1:0] CURSOR_SHAPE_HI_RST = 5'd15;
    localparam logic [MODE_W-1:0]     VIDEOMODE_RST       = 2'd0;

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_e;

    // Expand a 6-bit DAC component to 8 bits by replicating its top bits.
    function automatic logic [7:0] expand6(input logic [COMP_W-1:0] c);
        return {c, c[5:4]};
    endfunction

endpackage

// File: rtl/cga_ports_if.sv
// CPU I/O bus: address/strobes/write data towards the block, read data and hit back.
interface cga_ports_if;
    import cga_pkg::*;

    logic [ADDR_W-1:0] port_addr;
    logic              port_wr;
    logic              port_rd;
    logic [DATA_W-1:0] port_in;
    logic [DATA_W-1:0] port_out;
    logic              port_hit;

    modport master (
        output port_addr, port_wr, port_rd, port_in,
        input  port_out, port_hit
    );

    modport slave (
        input  port_addr, port_wr, port_rd, port_in,
        output port_out, port_hit
    );
endinterface

// File: rtl/cga_dac_port.sv
// DAC palette ports: write/read triplet sequencing, index registers, write pulse.
module cga_dac_port
    import cga_pkg::*;
(
    input  logic                  clock_25,
    input  logic                  reset,
    input  logic                  widx_wr,
    input  logic                  ridx_wr,
    input  logic                  data_wr,
    input  logic                  data_rd,
    input  logic [DATA_W-1:0]     wr_byte,
    output logic [DAC_IDX_W-1:0]  windex,
    output logic [DATA_W-1:0]     rd_byte_c,
    output logic                  dac_we,
    output logic [DAC_IDX_W-1:0]  dac_waddr,
    output logic [DAC_DATA_W-1:0] dac_wdata,
    output logic [DAC_IDX_W-1:0]  dac_raddr,
    input  logic [DAC_DATA_W-1:0] dac_rdata
);

    phase_e                wphase_q, wphase_d;
    phase_e                rphase_q, rphase_d;
    logic [DAC_IDX_W-1:0]  windex_q, windex_d;
    logic [DAC_IDX_W-1:0]  rindex_q, rindex_d;
    logic [COMP_W-1:0]     red_q, red_d;
    logic [COMP_W-1:0]     green_q, green_d;
    logic                  dac_we_q, dac_we_d;
    logic [DAC_IDX_W-1:0]  dac_waddr_q, dac_waddr_d;
    logic [DAC_DATA_W-1:0] dac_wdata_q, dac_wdata_d;

    // Only the top six bits of each component are returned to the CPU.
    logic dac_rdata_unused;
    assign dac_rdata_unused = ^{dac_rdata[31:24], dac_rdata[17:16],
                                dac_rdata[9:8], dac_rdata[1:0]};

    // State registers.
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            wphase_q    <= PH_R;
            rphase_q    <= PH_R;
            windex_q    <= '0;
            rindex_q    <= '0;
            red_q       <= '0;
            green_q     <= '0;
            dac_we_q    <= 1'b0;
            dac_waddr_q <= '0;
            dac_wdata_q <= '0;
        end else begin
            wphase_q    <= wphase_d;
            rphase_q    <= rphase_d;
            windex_q    <= windex_d;
            rindex_q    <= rindex_d;
            red_q       <= red_d;
            green_q     <= green_d;
            dac_we_q    <= dac_we_d;
            dac_waddr_q <= dac_waddr_d;
            dac_wdata_q <= dac_wdata_d;
        end
    end

    // Write triplet: latch R and G, emit the palette entry on B.
    always_comb begin
        wphase_d    = wphase_q;
        windex_d    = windex_q;
        red_d       = red_q;
        green_d     = green_q;
        dac_we_d    = 1'b0;
        dac_waddr_d = dac_waddr_q;
        dac_wdata_d = dac_wdata_q;
        if (widx_wr) begin
            windex_d = wr_byte;
            wphase_d = PH_R;
        end else if (data_wr) begin
            case (wphase_q)
                PH_R: begin
                    red_d    = wr_byte[COMP_W-1:0];
                    wphase_d = PH_G;
                end
                PH_G: begin
                    green_d  = wr_byte[COMP_W-1:0];
                    wphase_d = PH_B;
                end
                default: begin
                    dac_we_d    = 1'b1;
                    dac_waddr_d = windex_q;
                    dac_wdata_d = {8'h00, expand6(red_q), expand6(green_q),
                                   expand6(wr_byte[COMP_W-1:0])};
                    windex_d    = windex_q + DAC_IDX_W'(1);
                    wphase_d    = PH_R;
                end
            endcase
        end
    end

    // Read triplet: step R -> G -> B, bumping the read index after B.
    always_comb begin
        rphase_d = rphase_q;
        rindex_d = rindex_q;
        if (ridx_wr) begin
            rindex_d = wr_byte;
            rphase_d = PH_R;
        end else if (data_rd) begin
            case (rphase_q)
                PH_R:    rphase_d = PH_G;
                PH_G:    rphase_d = PH_B;
                default: begin
                    rphase_d = PH_R;
                    rindex_d = rindex_q + DAC_IDX_W'(1);
                end
            endcase
        end
    end

    // Component currently selected by the read phase, scaled back to 6 bits.
    always_comb begin
        rd_byte_c = '0;
        case (rphase_q)
            PH_R:    rd_byte_c = {2'b00, dac_rdata[23:18]};
            PH_G:    rd_byte_c = {2'b00, dac_rdata[15:10]};
            default: rd_byte_c = {2'b00, dac_rdata[7:2]};
        endcase
    end

    assign windex    = windex_q;
    assign dac_we    = dac_we_q;
    assign dac_waddr = dac_waddr_q;
    assign dac_wdata = dac_wdata_q;
    assign dac_raddr = rindex_q;

endmodule

// File: rtl/cga_ports.sv
// CPU-facing I/O decode for CRTC cursor/shape, mode, status and VGA DAC ports.
module cga_ports
    import cga_pkg::*;
(
    input  logic                  clock_25,
    input  logic                  reset,
    cga_ports_if.slave            bus,
    input  logic                  vretrace,
    output logic [CURSOR_W-1:0]   cursor,
    output logic [SHAPE_LO_W-1:0] cursor_shape_lo,
    output logic [SHAPE_HI_W-1:0] cursor_shape_hi,
    output logic [MODE_W-1:0]     videomode,
    output logic                  dac_we,
    output logic [DAC_IDX_W-1:0]  dac_waddr,
    output logic [DAC_DATA_W-1:0] dac_wdata,
    output logic [DAC_IDX_W-1:0]  dac_raddr,
    input  logic [DAC_DATA_W-1:0] dac_rdata
);

    logic [CRTC_IDX_W-1:0] crtc_index_q, crtc_index_d;
    logic [CURSOR_W-1:0]   cursor_q, cursor_d;
    logic [SHAPE_LO_W-1:0] shape_lo_q, shape_lo_d;
    logic [SHAPE_HI_W-1:0] shape_hi_q, shape_hi_d;
    logic [MODE_W-1:0]     videomode_q, videomode_d;
    logic [DATA_W-1:0]     port_out_q, port_out_d;
    logic                  port_hit_q, port_hit_d;

    logic                  wr_c, rd_c;
    logic [DATA_W-1:0]     crtc_rd_c;
    logic [DATA_W-1:0]     dac_rd_byte_c;
    logic [DAC_IDX_W-1:0]  windex;

    // A simultaneous write wins; the read is dropped.
    assign wr_c = bus.port_wr;
    assign rd_c = bus.port_rd & ~bus.port_wr;

    cga_dac_port u_dac (
        .clock_25  (clock_25),
        .reset     (reset),
        .widx_wr   (wr_c && (bus.port_addr == PORT_DAC_WINDEX)),
        .ridx_wr   (wr_c && (bus.port_addr == PORT_DAC_RINDEX)),
        .data_wr   (wr_c && (bus.port_addr == PORT_DAC_DATA)),
        .data_rd   (rd_c && (bus.port_addr == PORT_DAC_DATA)),
        .wr_byte   (bus.port_in),
        .windex    (windex),
        .rd_byte_c (dac_rd_byte_c),
        .dac_we    (dac_we),
        .dac_waddr (dac_waddr),
        .dac_wdata (dac_wdata),
        .dac_raddr (dac_raddr),
        .dac_rdata (dac_rdata)
    );

    // Register file and read/hit outputs.
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            crtc_index_q <= '0;
            cursor_q     <= '0;
            shape_lo_q   <= CURSOR_SHAPE_LO_RST;
            shape_hi_q   <= CURSOR_SHAPE_HI_RST;
            videomode_q  <= VIDEOMODE_RST;
            port_out_q   <= '0;
            port_hit_q   <= 1'b0;
        end else begin
            crtc_index_q <= crtc_index_d;
            cursor_q     <= cursor_d;
            shape_lo_q   <= shape_lo_d;
            shape_hi_q   <= shape_hi_d;
            videomode_q  <= videomode_d;
            port_out_q   <= port_out_d;
            port_hit_q   <= port_hit_d;
        end
    end

    // CRTC data readback selected by the current index.
    always_comb begin
        crtc_rd_c = '0;
        case (crtc_index_q)
            CRTC_CURSOR_START: crtc_rd_c = DATA_W'(shape_lo_q);
            CRTC_CURSOR_END:   crtc_rd_c = DATA_W'(shape_hi_q);
            CRTC_CURSOR_HI:    crtc_rd_c = DATA_W'(cursor_q[10:8]);
            CRTC_CURSOR_LO:    crtc_rd_c = cursor_q[7:0];
            default:           crtc_rd_c = '0;
        endcase
    end

    // Port decode: register writes and the read data mux.
    always_comb begin
        crtc_index_d = crtc_index_q;
        cursor_d     = cursor_q;
        shape_lo_d   = shape_lo_q;
        shape_hi_d   = shape_hi_q;
        videomode_d  = videomode_q;
        port_out_d   = port_out_q;
        port_hit_d   = 1'b0;
        if (wr_c) begin
            case (bus.port_addr)
                PORT_CRTC_INDEX: begin
                    crtc_index_d = bus.port_in[CRTC_IDX_W-1:0];
                    port_hit_d   = 1'b1;
                end
                PORT_CRTC_DATA: begin
                    port_hit_d = 1'b1;
                    case (crtc_index_q)
                        CRTC_CURSOR_START: shape_lo_d = bus.port_in[SHAPE_LO_W-1:0];
                        CRTC_CURSOR_END:   shape_hi_d = bus.port_in[SHAPE_HI_W-1:0];
                        CRTC_CURSOR_HI:    cursor_d[10:8] = bus.port_in[2:0];
                        CRTC_CURSOR_LO:    cursor_d[7:0]  = bus.port_in;
                        default: ;
                    endcase
                end
                PORT_MODE: begin
                    videomode_d = bus.port_in[MODE_W-1:0];
                    port_hit_d  = 1'b1;
                end
                PORT_STATUS, PORT_DAC_RINDEX, PORT_DAC_WINDEX, PORT_DAC_DATA:
                    port_hit_d = 1'b1;
                default: ;
            endcase
        end else if (rd_c) begin
            port_hit_d = 1'b1;
            case (bus.port_addr)
                PORT_CRTC_INDEX: port_out_d = DATA_W'(crtc_index_q);
                PORT_CRTC_DATA:  port_out_d = crtc_rd_c;
                PORT_MODE:       port_out_d = DATA_W'(videomode_q);
                PORT_STATUS:     port_out_d = {4'b0000, vretrace, 2'b00, vretrace};
                PORT_DAC_RINDEX: port_out_d = '0;
                PORT_DAC_WINDEX: port_out_d = windex;
                PORT_DAC_DATA:   port_out_d = dac_rd_byte_c;
                default:         port_hit_d = 1'b0;
            endcase
        end
    end

    assign bus.port_out    = port_out_q;
    assign bus.port_hit    = port_hit_q;
    assign cursor          = cursor_q;
    assign cursor_shape_lo = shape_lo_q;
    assign cursor_shape_hi = shape_hi_q;
    assign videomode       = videomode_q;

endmodule

// File: tb/tb_cga_ports.sv
// Scoreboard bench for cga_ports: expected reads and palette writes are queued
// as stimulus is driven and retired when the DUT produces them.
module tb_cga_ports;
    import cga_pkg::*;

    logic        clock_25;
    logic        reset;
    logic        vretrace;
    logic [10:0] cursor;
    logic [5:0]  cursor_shape_lo;
    logic [4:0]  cursor_shape_hi;
    logic [1:0]  videomode;
    logic        dac_we;
    logic [7:0]  dac_waddr;
    logic [31:0] dac_wdata;
    logic [7:0]  dac_raddr;
    logic [31:0] dac_rdata;

    cga_ports_if bus ();

    cga_ports dut (
        .clock_25        (clock_25),
        .reset           (reset),
        .bus             (bus),
        .vretrace        (vretrace),
        .cursor          (cursor),
        .cursor_shape_lo (cursor_shape_lo),
        .cursor_shape_hi (cursor_shape_hi),
        .videomode       (videomode),
        .dac_we          (dac_we),
        .dac_waddr       (dac_waddr),
        .dac_wdata       (dac_wdata),
        .dac_raddr       (dac_raddr),
        .dac_rdata       (dac_rdata)
    );

    initial clock_25 = 1'b0;
    always #20 clock_25 = ~clock_25;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } dac_exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pulses_seen = 0;
    int          pulses_exp  = 0;
    dac_exp_t    dac_q[$];
    logic [7:0]  rd_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Palette-write monitor: every pulse must match the oldest queued entry.
    always @(negedge clock_25) begin
        if (dac_we === 1'b1) begin
            dac_exp_t e;
            pulses_seen++;
            if (dac_q.size() == 0) begin
                check("dac_pulse_expected", 32'(dac_q.size()), 32'd1);
            end else begin
                e = dac_q.pop_front();
                check("dac_waddr", {24'h0, dac_waddr}, {24'h0, e.addr});
                check("dac_wdata", dac_wdata, e.data);
            end
        end
    end

    task automatic expect_dac(input logic [7:0] addr, input logic [31:0] data);
        dac_exp_t e;
        e.addr = addr;
        e.data = data;
        dac_q.push_back(e);
        pulses_exp++;
    endtask

    task automatic io_wr(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clock_25);
        bus.port_addr = addr;
        bus.port_in   = data;
        bus.port_wr   = 1'b1;
        @(negedge clock_25);
        bus.port_wr   = 1'b0;
    endtask

    task automatic io_rd(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        logic [7:0] e;
        rd_q.push_back(exp);
        @(negedge clock_25);
        bus.port_addr = addr;
        bus.port_rd   = 1'b1;
        @(negedge clock_25);
        bus.port_rd   = 1'b0;
        check({tag, "_hit"}, 32'(bus.port_hit), 32'd1);
        e = rd_q.pop_front();
        check(tag, 32'(bus.port_out), 32'(e));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock_25);
    endtask

    task automatic pulse_reset();
        @(negedge clock_25);
        reset = 1'b1;
        @(negedge clock_25);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        vretrace      = 1'b0;
        dac_rdata     = 32'h0;
        bus.port_addr = 16'h0;
        bus.port_in   = 8'h0;
        bus.port_wr   = 1'b0;
        bus.port_rd   = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(1);

        // Reset state.
        check("rst_cursor",   32'(cursor), 32'd0);
        check("rst_shape_lo", 32'(cursor_shape_lo), 32'd14);
        check("rst_shape_hi", 32'(cursor_shape_hi), 32'd15);
        check("rst_mode",     32'(videomode), 32'd0);
        check("rst_dac_we",   32'(dac_we), 32'd0);
        check("rst_port_out", 32'(bus.port_out), 32'd0);
        check("rst_port_hit", 32'(bus.port_hit), 32'd0);
        check("rst_raddr",    32'(dac_raddr), 32'd0);

        // Cursor position through the CRTC index/data pair.
        io_wr(16'h03D4, 8'h0E);
        io_wr(16'h03D5, 8'h07);
        io_wr(16'h03D4, 8'h0F);
        io_wr(16'h03D5, 8'hCF);
        check("cursor", 32'(cursor), 32'h7CF);
        io_rd("crtc_lo_rd", 16'h03D5, 8'hCF);
        io_rd("crtc_idx_rd", 16'h03D4, 8'h0F);
        io_wr(16'h03D4, 8'h0A);
        io_wr(16'h03D5, 8'hFF);
        check("shape_lo", 32'(cursor_shape_lo), 32'h3F);
        io_rd("shape_lo_rd", 16'h03D5, 8'h3F);
        io_wr(16'h03D4, 8'h05);
        io_wr(16'h03D5, 8'h55);
        io_rd("crtc_other_rd", 16'h03D5, 8'h00);

        // Palette write at the top index, with windex wrap.
        io_wr(16'h03C8, 8'hFF);
        io_wr(16'h03C9, 8'h3F);
        io_wr(16'h03C9, 8'h00);
        expect_dac(8'hFF, 32'h00FF0082);
        io_wr(16'h03C9, 8'h20);
        idle(1);
        io_rd("windex_wrap", 16'h03C8, 8'h00);

        // Palette read triplet.
        dac_rdata = 32'h00FF0082;
        io_wr(16'h03C7, 8'h05);
        check("raddr_set", 32'(dac_raddr), 32'h05);
        idle(1);
        io_rd("dac_rd_r", 16'h03C9, 8'h3F);
        idle(1);
        io_rd("dac_rd_g", 16'h03C9, 8'h00);
        idle(1);
        io_rd("dac_rd_b", 16'h03C9, 8'h20);
        check("raddr_inc", 32'(dac_raddr), 32'h06);

        // Reset in the middle of a triplet discards it.
        io_wr(16'h03C9, 8'h10);
        io_wr(16'h03C9, 8'h11);
        pulse_reset();
        check("rst2_cursor", 32'(cursor), 32'd0);
        io_wr(16'h03C9, 8'h01);
        io_wr(16'h03C9, 8'h02);
        expect_dac(8'h00, 32'h0004080C);
        io_wr(16'h03C9, 8'h03);
        idle(2);

        // Status register reflects vretrace.
        vretrace = 1'b1;
        io_rd("status", 16'h03DA, 8'h09);
        vretrace = 1'b0;

        // Simultaneous write and read: write wins, read data untouched.
        @(negedge clock_25);
        bus.port_addr = 16'h03D8;
        bus.port_in   = 8'h02;
        bus.port_wr   = 1'b1;
        bus.port_rd   = 1'b1;
        @(negedge clock_25);
        bus.port_wr   = 1'b0;
        bus.port_rd   = 1'b0;
        check("wr_rd_mode", 32'(videomode), 32'd2);
        check("wr_rd_hit",  32'(bus.port_hit), 32'd1);
        check("wr_rd_out",  32'(bus.port_out), 32'h09);
        io_rd("mode_rd", 16'h03D8, 8'h02);

        // Undecoded address: no hit, read data held.
        io_wr(16'h03D0, 8'hAA);
        check("undec_wr_hit", 32'(bus.port_hit), 32'd0);
        @(negedge clock_25);
        bus.port_addr = 16'h03D0;
        bus.port_rd   = 1'b1;
        @(negedge clock_25);
        bus.port_rd   = 1'b0;
        check("undec_rd_hit", 32'(bus.port_hit), 32'd0);
        check("undec_rd_out", 32'(bus.port_out), 32'h02);

        // A 3C8 write mid-triplet restarts it at the new index.
        io_wr(16'h03C8, 8'h10);
        io_wr(16'h03C9, 8'h01);
        io_wr(16'h03C8, 8'h20);
        io_wr(16'h03C9, 8'h3F);
        io_wr(16'h03C9, 8'h3F);
        expect_dac(8'h20, 32'h00FFFFFF);
        io_wr(16'h03C9, 8'h3F);
        idle(2);
        io_rd("windex_after", 16'h03C8, 8'h21);

        check("dac_q_drained", 32'(dac_q.size()), 32'd0);
        check("dac_pulse_count", 32'(pulses_seen), 32'(pulses_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
